uart_tx_buffered: RTL and testbench

Parametrised, FIFO-buffered UART transmitter that replaces the CPU's single-byte `tx_Data`/`tx_DataValid` output path. The CPU pushes characters through a valid/ready handshake. The block queues them and serialises each one as a configurable 8N1-style frame on `tx` with no inter-frame gap. It sits between the multi-cycle core's store-to-UART path and the board pin.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/uart_tx_buffered.sv | 150 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding
// and parity mode constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO. Pointers carry one extra wrap bit so that
// full and empty stay distinguishable when the address bits coincide.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset discards all queued entries.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter. Characters enter through a valid/ready
// handshake, are queued, and are serialised as start/data/parity/stop frames
// back to back. The serial output is registered, so tx follows the FSM state
// by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          clr_overflow,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned        BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]         DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]         STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_e                     r_state;
  tx_state_e                     w_state_next;
  logic [BAUD_W-1:0]             r_baud;
  logic [3:0]                    r_bit_idx;
  logic [DATA_BITS-1:0]          r_shift;
  logic                          r_par;
  logic                          r_tx;
  logic                          r_overflow;
  logic                          w_tx_next;
  logic                          w_pop;
  logic                          w_push;
  logic                          w_bit_end;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic [DATA_BITS-1:0]          w_fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0]   w_fifo_count;

  assign in_ready   = ~w_fifo_full & ~reset;
  assign w_push     = in_valid & in_ready;
  assign w_bit_end  = (r_baud == BAUD_LAST);
  assign tx         = r_tx;
  assign busy       = (r_state != ST_IDLE) | (w_fifo_count != '0);
  assign fifo_count = w_fifo_count;
  assign overflow   = r_overflow;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (in_data),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Next-state, pop request and next serial bit from the current state.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        w_tx_next = 1'b0;
        if (w_bit_end) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        w_tx_next = r_shift[0];
        if (w_bit_end && (r_bit_idx == DATA_LAST))
          w_state_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      end
      ST_PAR: begin
        w_tx_next = r_par;
        if (w_bit_end) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_end && (r_bit_idx == STOP_LAST)) begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register, baud/bit counters, shift register and registered tx.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      if ((w_state_next != r_state) || w_bit_end)
        r_baud <= '0;
      else if (r_state != ST_IDLE)
        r_baud <= r_baud + 1'b1;
      if (w_state_next != r_state)
        r_bit_idx <= '0;
      else if (w_bit_end)
        r_bit_idx <= r_bit_idx + 1'b1;
      if (w_pop) begin
        r_shift <= w_fifo_rdata;
        r_par   <= (^w_fifo_rdata) ^ (PARITY == PAR_ODD);
      end else if ((r_state == ST_DATA) && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  // Sticky overflow flag; a new overflow takes priority over a clear.
  always_ff @(posedge clk) begin
    if (reset)
      r_overflow <= 1'b0;
    else if (in_valid && w_fifo_full)
      r_overflow <= 1'b1;
    else if (clr_overflow)
      r_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: single frame timing, burst through a
// full FIFO, overflow flag, reset mid-frame, odd/even parity framing.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       in_ready, tx, busy, overflow;
  logic [4:0] fifo_count;

  logic [6:0] p_data = '0;
  logic       p_valid_o = 1'b0, p_valid_e = 1'b0;
  logic       p_ready_o, p_tx_o, p_busy_o, p_ovf_o;
  logic       p_ready_e, p_tx_e, p_busy_e, p_ovf_e;
  logic [4:0] p_count_o, p_count_e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT (4),
    .DATA_BITS    (8),
    .FIFO_DEPTH   (16),
    .PARITY       (0),
    .STOP_BITS    (1)
  ) dut (
    .clk (clk), .reset (reset), .in_data (in_data), .in_valid (in_valid),
    .in_ready (in_ready), .clr_overflow (clr_overflow), .tx (tx),
    .busy (busy), .fifo_count (fifo_count), .overflow (overflow)
  );

  uart_tx_buffered #(
    .CLKS_PER_BIT (4),
    .DATA_BITS    (7),
    .FIFO_DEPTH   (16),
    .PARITY       (1),
    .STOP_BITS    (2)
  ) dut_odd (
    .clk (clk), .reset (reset), .in_data (p_data), .in_valid (p_valid_o),
    .in_ready (p_ready_o), .clr_overflow (1'b0), .tx (p_tx_o),
    .busy (p_busy_o), .fifo_count (p_count_o), .overflow (p_ovf_o)
  );

  uart_tx_buffered #(
    .CLKS_PER_BIT (4),
    .DATA_BITS    (7),
    .FIFO_DEPTH   (16),
    .PARITY       (2),
    .STOP_BITS    (2)
  ) dut_even (
    .clk (clk), .reset (reset), .in_data (p_data), .in_valid (p_valid_e),
    .in_ready (p_ready_e), .clr_overflow (1'b0), .tx (p_tx_e),
    .busy (p_busy_e), .fifo_count (p_count_e), .overflow (p_ovf_e)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_tx(input int sel);
    return (sel == 0) ? tx : (sel == 1) ? p_tx_o : p_tx_e;
  endfunction

  function automatic logic sel_busy(input int sel);
    return (sel == 0) ? busy : (sel == 1) ? p_busy_o : p_busy_e;
  endfunction

  // Wait (bounded) until the selected line shows a start bit.
  task automatic wait_start(input string tag, input int sel, input int limit);
    int n = 0;
    while (sel_tx(sel) !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " start seen"}, 32'(sel_tx(sel) === 1'b0), 32'd1);
  endtask

  // Called on the first start-bit cycle; checks every cycle of the frame
  // (4 clocks per bit) and leaves off on the cycle after the frame.
  task automatic rx_frame(input string tag, input logic [11:0] bits,
                          input int nbits, input int sel, input bit last);
    for (int j = 0; j < nbits * 4; j++) begin
      chk($sformatf("%s tx bit%0d cyc%0d", tag, j / 4, j % 4),
          32'(sel_tx(sel)), 32'(bits[j / 4]));
      if (j == nbits * 4 - 2)
        chk({tag, " busy before end"}, 32'(sel_busy(sel)), 32'd1);
      if (j == nbits * 4 - 1)
        chk({tag, " busy at end"}, 32'(sel_busy(sel)), 32'(!last));
      @(negedge clk);
    end
  endtask

  // Present a character and hold in_valid until it is accepted.
  task automatic push_main(input logic [7:0] d, input int limit);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("push %02h ready", d), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_low;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst tx",         32'(tx),         32'd1);
    chk("rst in_ready",   32'(in_ready),   32'd0);
    chk("rst busy",       32'(busy),       32'd0);
    chk("rst fifo_count", 32'(fifo_count), 32'd0);
    chk("rst overflow",   32'(overflow),   32'd0);
    chk("rst par tx",     32'(p_tx_o),     32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("post rst in_ready", 32'(in_ready), 32'd1);

    // Single frame, 0xA5
    push_main(8'hA5, 5);
    chk("single count after accept", 32'(fifo_count), 32'd1);
    chk("single tx idle N",          32'(tx),         32'd1);
    chk("single busy N",             32'(busy),       32'd1);
    @(negedge clk);
    chk("single tx idle N+1",        32'(tx),         32'd1);
    chk("single count after pop",    32'(fifo_count), 32'd0);
    @(negedge clk);
    chk("single start latency",      32'(tx),         32'd0);
    rx_frame("A5", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 0, 1'b1);
    chk("single tx idle after", 32'(tx),   32'd1);
    chk("single busy after",    32'(busy), 32'd0);

    // Burst of 20 characters through a 16-entry FIFO
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          push_main(8'(i), 400);
          if (i == 15) begin
            chk("burst count 15", 32'(fifo_count), 32'd15);
            chk("burst ready 15", 32'(in_ready),   32'd1);
          end
          if (i == 16) begin
            chk("burst count full", 32'(fifo_count), 32'd16);
            chk("burst ready full", 32'(in_ready),   32'd0);
          end
        end
      end
      begin
        wait_start("burst", 0, 20);
        for (int k = 0; k < 20; k++)
          rx_frame($sformatf("burst%0d", k), {2'b00, 1'b1, 8'(k), 1'b0},
                   10, 0, k == 19);
      end
    join
    chk("burst drained count", 32'(fifo_count), 32'd0);
    chk("burst held-valid ovf", 32'(overflow),  32'd1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("burst ovf cleared", 32'(overflow), 32'd0);

    // Overflow: fill, force a push while full, clear interactions
    fork
      begin
        for (int i = 0; i < 17; i++)
          push_main(8'(8'h40 + i), 5);
        chk("ovf full count", 32'(fifo_count), 32'd16);
        chk("ovf full ready", 32'(in_ready),   32'd0);
        chk("ovf not yet",    32'(overflow),   32'd0);
        in_data  = 8'hEE;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ovf set",            32'(overflow),   32'd1);
        chk("ovf count unchanged", 32'(fifo_count), 32'd16);
        in_valid     = 1'b1;
        clr_overflow = 1'b1;
        @(negedge clk);
        in_valid     = 1'b0;
        clr_overflow = 1'b0;
        chk("ovf set beats clear", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("ovf clear alone", 32'(overflow), 32'd0);
      end
      begin
        wait_start("ovf", 0, 20);
        for (int k = 0; k < 17; k++)
          rx_frame($sformatf("ovf%0d", k), {2'b00, 1'b1, 8'(8'h40 + k), 1'b0},
                   10, 0, k == 16);
      end
    join
    chk("ovf idle tx", 32'(tx), 32'd1);

    // Reset mid-frame with characters queued
    push_main(8'h22, 5);
    push_main(8'h33, 5);
    push_main(8'h44, 5);
    wait_start("rstmid", 0, 5);
    chk("rstmid queued", 32'(fifo_count), 32'd2);
    repeat (20) @(negedge clk);
    chk("rstmid data bit4", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    chk("rstmid ready low", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid tx",    32'(tx),         32'd1);
    chk("rstmid count", 32'(fifo_count), 32'd0);
    chk("rstmid busy",  32'(busy),       32'd0);
    any_low = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) any_low = 1'b1;
    end
    chk("rstmid no frame", 32'(any_low), 32'd0);
    push_main(8'h5A, 5);
    wait_start("after rst", 0, 5);
    rx_frame("5A", {2'b00, 1'b1, 8'h5A, 1'b0}, 10, 0, 1'b1);

    // Parity: 7 data bits, 2 stop bits, char 0x03 has two ones
    p_data    = 7'h03;
    p_valid_o = 1'b1;
    @(negedge clk);
    p_valid_o = 1'b0;
    wait_start("odd", 1, 5);
    rx_frame("odd", {1'b0, 2'b11, 1'b1, 7'h03, 1'b0}, 11, 1, 1'b1);
    p_valid_e = 1'b1;
    @(negedge clk);
    p_valid_e = 1'b0;
    wait_start("even", 2, 5);
    rx_frame("even", {1'b0, 2'b11, 1'b0, 7'h03, 1'b0}, 11, 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
